// File: rtl/streebog_s_inv_table_pkg.sv
// Shared definitions for the Streebog inverse S-box table builder.
package streebog_s_inv_table_pkg;

    typedef enum logic [1:0] {
        ST_BUILD = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int S_TABLE_DEPTH = 256;
    localparam int BUILD_EDGES   = 257;

endpackage

// File: rtl/streebog_rom_s_table.sv
// Forward Streebog S-transform table pi as a registered ROM with read enable.
module streebog_rom_s_table (
    input  logic       clk,
    input  logic       en,
    input  logic [7:0] addr,
    output logic [7:0] dout
);

    // Element 0 is the leftmost byte.
    localparam logic [0:255][7:0] PI_TABLE = {
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= PI_TABLE[addr];
        end
    end

endmodule

// File: rtl/streebog_s_inv_table.sv
// Inverse Streebog S-box: builds pi^-1 into a RAM after reset by walking the
// forward ROM, checks bijectivity, then serves 1-cycle-latency lookups.
module streebog_s_inv_table
    import streebog_s_inv_table_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       ready,
    output logic       err
);

    state_t                   state_reg;
    state_t                   state_next;
    logic [7:0]               i_reg;
    logic [7:0]               idx_d_reg;
    logic                     wr_pend_reg;
    logic                     err_reg;
    logic                     dout_valid_reg;
    logic                     has_data_reg;
    logic [S_TABLE_DEPTH-1:0] bitmap_reg;
    logic [S_TABLE_DEPTH-1:0] bitmap_next;
    logic [7:0]               rom_dout;
    logic [7:0]               ram_q;
    logic                     rom_en;
    logic                     wr_en;
    logic                     rd_en;
    logic                     dup_hit;

    logic [7:0] ram_mem [S_TABLE_DEPTH];

    streebog_rom_s_table u_rom (
        .clk  (clk),
        .en   (rom_en),
        .addr (i_reg),
        .dout (rom_dout)
    );

    assign rom_en = (state_reg == ST_BUILD);
    // A write follows every ROM access by one edge, so it can only be live in
    // BUILD or DRAIN and never overlaps a READY-state lookup.
    assign wr_en  = wr_pend_reg;
    assign ready  = (state_reg == ST_READY);
    assign rd_en  = ready && ena;

    assign dup_hit = wr_en && bitmap_reg[rom_dout];

    generate
        for (genvar gi = 0; gi < S_TABLE_DEPTH; gi++) begin : g_bitmap
            assign bitmap_next[gi] = bitmap_reg[gi] | (wr_en && (rom_dout == 8'(gi)));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BUILD: if (i_reg == 8'(S_TABLE_DEPTH - 1)) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_BUILD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_BUILD;
            i_reg          <= 8'h00;
            idx_d_reg      <= 8'h00;
            wr_pend_reg    <= 1'b0;
            err_reg        <= 1'b0;
            dout_valid_reg <= 1'b0;
            has_data_reg   <= 1'b0;
            bitmap_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            wr_pend_reg <= rom_en;
            bitmap_reg  <= bitmap_next;
            if (rom_en) begin
                idx_d_reg <= i_reg;
                i_reg     <= i_reg + 8'h01;
            end
            // The completeness test uses bitmap_next so the final DRAIN write counts.
            if (dup_hit || ((state_reg == ST_DRAIN) && !(&bitmap_next))) begin
                err_reg <= 1'b1;
            end
            dout_valid_reg <= rd_en;
            if (rd_en) begin
                has_data_reg <= 1'b1;
            end
        end
    end

    // Kept free of reset so it maps onto a simple dual-port block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_mem[rom_dout] <= idx_d_reg;
        end
        if (rd_en) begin
            ram_q <= ram_mem[din];
        end
    end

    assign dout       = has_data_reg ? ram_q : 8'h00;
    assign dout_valid = dout_valid_reg;
    assign err        = err_reg;

endmodule
